// File: rtl/viterbi_k4_pkg.sv
// Shared definitions for the rate-1/2, K=4 (17/15 octal) convolutional code and its decoder.
package viterbi_k4_pkg;

  localparam int unsigned K            = 4;
  localparam int unsigned NUM_STATES   = 8;
  localparam int unsigned PM_W_DEFAULT = 6;

  // Generator taps ordered {u, d1, d2, d3}.
  localparam logic [3:0] G1 = 4'b1111;
  localparam logic [3:0] G0 = 4'b1101;

  typedef logic [PM_W_DEFAULT-1:0] pm_t;

  // Code symbol emitted when input u leaves trellis state {d1, d2, d3}.
  function automatic logic [1:0] expected_symbol(input logic [2:0] state, input logic u);
    logic [3:0] taps;
    taps = {u, state};
    return {^(taps & G1), ^(taps & G0)};
  endfunction

endpackage

// File: rtl/viterbi_acs_k4.sv
// One add-compare-select node: two saturating candidates, ties resolved toward predecessor p0.
module viterbi_acs_k4 #(
  parameter int unsigned PM_W = 6
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  logic [PM_W:0]   sum0;
  logic [PM_W:0]   sum1;
  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    sum0   = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
    sum1   = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
    cand0  = (sum0 > PM_MAX) ? PM_MAX[PM_W-1:0] : sum0[PM_W-1:0];
    cand1  = (sum1 > PM_MAX) ? PM_MAX[PM_W-1:0] : sum1[PM_W-1:0];
    dec    = (cand1 < cand0);
    pm_new = dec ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_decoder_k4.sv
// Hard-decision 8-state Viterbi decoder with register-exchange survivors and fixed decode delay.
module viterbi_decoder_k4
  import viterbi_k4_pkg::*;
#(
  parameter int unsigned TB_DEPTH  = 20,
  parameter int unsigned PM_W      = 6,
  parameter int unsigned INIT_BIAS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      in_bits,
  output logic            out_valid,
  output logic            out_bit,
  output logic [PM_W-1:0] best_metric
);

  localparam int unsigned CNT_W      = $clog2(TB_DEPTH + 1);
  localparam int unsigned PM_MAX_INT = (1 << PM_W) - 1;
  // Clamp the start bias so an oversized INIT_BIAS cannot wrap.
  localparam logic [PM_W-1:0] PM_BIAS =
    PM_W'((INIT_BIAS > PM_MAX_INT) ? PM_MAX_INT : INIT_BIAS);

  logic [PM_W-1:0]       pm_q    [NUM_STATES];
  logic [PM_W-1:0]       acs_pm  [NUM_STATES];
  logic [PM_W-1:0]       norm_pm [NUM_STATES];
  logic [TB_DEPTH-1:0]   surv_q  [NUM_STATES];
  logic [TB_DEPTH-1:0]   surv_d  [NUM_STATES];
  logic [NUM_STATES-1:0] dec;
  logic [CNT_W-1:0]      fill_q;
  logic [PM_W-1:0]       min_pm;
  logic [2:0]            best;
  logic                  best_found;

  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam logic [2:0] N  = 3'(n);
    localparam logic [2:0] P0 = {N[1:0], 1'b0};
    localparam logic [2:0] P1 = {N[1:0], 1'b1};

    logic [1:0] diff0;
    logic [1:0] diff1;
    logic [1:0] bm0;
    logic [1:0] bm1;
    logic [2:0] sel;

    assign diff0 = in_bits ^ expected_symbol(P0, N[2]);
    assign diff1 = in_bits ^ expected_symbol(P1, N[2]);
    assign bm0   = {1'b0, diff0[1]} + {1'b0, diff0[0]};
    assign bm1   = {1'b0, diff1[1]} + {1'b0, diff1[0]};

    viterbi_acs_k4 #(
      .PM_W (PM_W)
    ) u_acs (
      .pm0    (pm_q[P0]),
      .pm1    (pm_q[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (acs_pm[n]),
      .dec    (dec[n])
    );

    // Register exchange: inherit the winning predecessor's history, append the hypothesised bit.
    assign sel       = dec[n] ? P1 : P0;
    assign surv_d[n] = {surv_q[sel][TB_DEPTH-2:0], N[2]};
  end

  always_comb begin
    min_pm = acs_pm[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (acs_pm[i] < min_pm) min_pm = acs_pm[i];
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      norm_pm[i] = acs_pm[i] - min_pm;
    end
    best       = 3'd0;
    best_found = 1'b0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (!best_found && norm_pm[i] == '0) begin
        best       = 3'(i);
        best_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_BIAS;
        surv_q[i] <= '0;
      end
      fill_q      <= '0;
      out_valid   <= 1'b0;
      out_bit     <= 1'b0;
      best_metric <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        for (int i = 0; i < NUM_STATES; i++) begin
          pm_q[i]   <= norm_pm[i];
          surv_q[i] <= surv_d[i];
        end
        if (fill_q < CNT_W'(TB_DEPTH)) fill_q <= fill_q + 1'b1;
        out_valid   <= (fill_q >= CNT_W'(TB_DEPTH - 1));
        out_bit     <= surv_d[best][TB_DEPTH-1];
        best_metric <= norm_pm[best];
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_k4.sv
// Self-checking bench: directed scenarios plus a randomized noisy stream against a path-tracking model.
module tb_viterbi_decoder_k4;

  localparam int TB_DEPTH  = 20;
  localparam int PM_W      = 6;
  localparam int INIT_BIAS = 8;
  localparam int NS        = 8;
  localparam int PM_SAT    = (1 << PM_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [1:0]      in_bits;
  logic            out_valid;
  logic            out_bit;
  logic [PM_W-1:0] best_metric;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  viterbi_decoder_k4 #(
    .TB_DEPTH  (TB_DEPTH),
    .PM_W      (PM_W),
    .INIT_BIAS (INIT_BIAS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bits     (in_bits),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .best_metric (best_metric)
  );

  // Output collector; inputs only change on the falling edge, so in_valid here is the sampled value.
  bit got_q[$];
  int idle_viol  = 0;
  int bm_nonzero = 0;
  int sat_hits   = 0;

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      got_q.push_back(out_bit);
      if (in_valid !== 1'b1) idle_viol++;
    end
    if (best_metric !== '0) bm_nonzero++;
    for (int i = 0; i < NS; i++) begin
      if (dut.pm_q[i] == PM_W'(PM_SAT)) sat_hits++;
    end
  end

  // Reference model: full path metrics as ints, each survivor path kept as a bit history.
  int    m_pm[NS];
  longint m_hist[NS];
  int    m_k;
  bit    exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pm[i]   = (i == 0) ? 0 : INIT_BIAS;
      m_hist[i] = 0;
    end
    m_k = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [1:0] sym);
    int     npm[NS];
    longint nh[NS];
    int     mn;
    int     best;
    for (int n = 0; n < NS; n++) begin
      int u;
      int best_p;
      int best_c;
      u      = n >> 2;
      best_p = -1;
      best_c = 0;
      // Predecessors are the two states that shift into n; the even one is tried first.
      for (int c = 0; c < 2; c++) begin
        int p;
        int e1;
        int e0;
        int cost;
        p    = ((n & 3) << 1) + c;
        e1   = u ^ ((p >> 2) & 1) ^ ((p >> 1) & 1) ^ (p & 1);
        e0   = u ^ ((p >> 2) & 1) ^ (p & 1);
        cost = m_pm[p] + ((e1 != int'(sym[1])) ? 1 : 0) + ((e0 != int'(sym[0])) ? 1 : 0);
        if (cost > PM_SAT) cost = PM_SAT;
        if (best_p < 0 || cost < best_c) begin
          best_p = p;
          best_c = cost;
        end
      end
      npm[n] = best_c;
      nh[n]  = (m_hist[best_p] << 1) | longint'(u);
    end
    mn = npm[0];
    for (int n = 1; n < NS; n++) if (npm[n] < mn) mn = npm[n];
    best = -1;
    for (int n = 0; n < NS; n++) begin
      m_pm[n]   = npm[n] - mn;
      m_hist[n] = nh[n];
      if (best < 0 && m_pm[n] == 0) best = n;
    end
    m_k++;
    if (m_k >= TB_DEPTH) exp_q.push_back(m_hist[best][TB_DEPTH-1]);
  endtask

  // Stimulus primitives.
  bit         msg_q[$];
  logic [1:0] sym_q[$];
  bit         ref_q[$];

  task automatic send(input logic [1:0] sym);
    @(negedge clk);
    in_valid = 1'b1;
    in_bits  = sym;
    model_step(sym);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_bits  = 2'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
  endtask

  // Encode msg_q followed by 3 zero tail bits and TB_DEPTH-1 zero padding symbols.
  task automatic build_syms();
    bit u, d1, d2, d3;
    d1 = 0;
    d2 = 0;
    d3 = 0;
    sym_q.delete();
    for (int i = 0; i < msg_q.size() + 3 + TB_DEPTH - 1; i++) begin
      u = (i < msg_q.size()) ? msg_q[i] : 1'b0;
      sym_q.push_back({u ^ d1 ^ d2 ^ d3, u ^ d1 ^ d3});
      d3 = d2;
      d2 = d1;
      d1 = u;
    end
  endtask

  task automatic random_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(1'($urandom));
  endtask

  // Scenarios.
  task automatic test_reset();
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_bit !== 1'b0 || best_metric !== '0) begin
      miscompares++;
      $display("FAIL reset_held: got valid=%b bit=%b metric=%0d, need 0/0/0",
               out_valid, out_bit, best_metric);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    idle(3);
    vectors++;
    if (out_valid !== 1'b0 || out_bit !== 1'b0 || best_metric !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got valid=%b bit=%b metric=%0d, need 0/0/0",
               out_valid, out_bit, best_metric);
    end
  endtask

  task automatic test_all_zero();
    int ones;
    for (int k = 1; k <= 40; k++) begin
      send(2'b00);
      @(posedge clk);
      #2;
      if (k == TB_DEPTH - 1) begin
        vectors++;
        if (got_q.size() != 0) begin
          miscompares++;
          $display("FAIL zero_latency_early: got %0d outputs after %0d symbols, need 0",
                   got_q.size(), k);
        end
      end
      if (k == TB_DEPTH) begin
        vectors++;
        if (got_q.size() != 1) begin
          miscompares++;
          $display("FAIL zero_latency_first: got %0d outputs after %0d symbols, need 1",
                   got_q.size(), k);
        end
      end
    end
    idle(3);
    vectors++;
    if (got_q.size() != 21) begin
      miscompares++;
      $display("FAIL zero_count: got %0d outputs, need 21", got_q.size());
    end
    ones = 0;
    foreach (got_q[i]) if (got_q[i]) ones++;
    vectors++;
    if (ones != 0) begin
      miscompares++;
      $display("FAIL zero_bits: got %0d ones, need 0", ones);
    end
  endtask

  task automatic test_impulse();
    bit e;
    do_reset();
    msg_q.delete();
    msg_q.push_back(1'b1);
    for (int i = 1; i < 20; i++) msg_q.push_back(1'b0);
    build_syms();
    foreach (sym_q[i]) send(sym_q[i]);
    idle(3);
    vectors++;
    if (got_q.size() != msg_q.size() + 3) begin
      miscompares++;
      $display("FAIL impulse_count: got %0d, need %0d", got_q.size(), msg_q.size() + 3);
    end
    for (int i = 0; i < got_q.size() && i < msg_q.size() + 3; i++) begin
      e = (i == 0);
      vectors++;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL impulse_bit[%0d]: got %b, need %b", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_error_correction();
    bit e;
    do_reset();
    random_msg(64);
    build_syms();
    sym_q[10] = sym_q[10] ^ (2'b01 << $urandom_range(1));
    sym_q[30] = sym_q[30] ^ (2'b01 << $urandom_range(1));
    foreach (sym_q[i]) send(sym_q[i]);
    idle(3);
    vectors++;
    if (got_q.size() != msg_q.size() + 3) begin
      miscompares++;
      $display("FAIL ecc_count: got %0d, need %0d", got_q.size(), msg_q.size() + 3);
    end
    for (int i = 0; i < got_q.size() && i < msg_q.size() + 3; i++) begin
      e = (i < msg_q.size()) ? msg_q[i] : 1'b0;
      vectors++;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL ecc_bit[%0d]: got %b, need %b", i, got_q[i], e);
      end
    end
    ref_q = got_q;
  endtask

  task automatic test_gapped();
    do_reset();
    idle_viol = 0;
    foreach (sym_q[i]) begin
      send(sym_q[i]);
      idle($urandom_range(3, 1));
    end
    idle(3);
    vectors++;
    if (got_q.size() != ref_q.size()) begin
      miscompares++;
      $display("FAIL gap_count: got %0d, need %0d", got_q.size(), ref_q.size());
    end
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== ref_q[i]) begin
        miscompares++;
        $display("FAIL gap_bit[%0d]: got %b, need %b", i, got_q[i], ref_q[i]);
      end
    end
    vectors++;
    if (idle_viol != 0) begin
      miscompares++;
      $display("FAIL gap_idle_valid: got %0d idle-cycle outputs, need 0", idle_viol);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit e;
    do_reset();
    random_msg(40);
    build_syms();
    for (int i = 0; i < 25; i++) send(sym_q[i]);
    do_reset();
    random_msg(40);
    build_syms();
    for (int i = 0; i < sym_q.size(); i++) begin
      send(sym_q[i]);
      if (i == TB_DEPTH - 2) begin
        @(posedge clk);
        #2;
        vectors++;
        if (got_q.size() != 0) begin
          miscompares++;
          $display("FAIL rst_mid_stale: got %0d outputs after %0d symbols, need 0",
                   got_q.size(), i + 1);
        end
      end
    end
    idle(3);
    vectors++;
    if (got_q.size() != msg_q.size() + 3) begin
      miscompares++;
      $display("FAIL rst_mid_count: got %0d, need %0d", got_q.size(), msg_q.size() + 3);
    end
    for (int i = 0; i < got_q.size() && i < msg_q.size() + 3; i++) begin
      e = (i < msg_q.size()) ? msg_q[i] : 1'b0;
      vectors++;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL rst_mid_bit[%0d]: got %b, need %b", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_long_random();
    bit u, d1, d2, d3;
    logic [1:0] s;
    do_reset();
    bm_nonzero = 0;
    sat_hits   = 0;
    d1 = 0;
    d2 = 0;
    d3 = 0;
    for (int i = 0; i < 10000; i++) begin
      u = 1'($urandom);
      s = {u ^ d1 ^ d2 ^ d3, u ^ d1 ^ d3};
      d3 = d2;
      d2 = d1;
      d1 = u;
      if ($urandom_range(99) < 5) s[1] = ~s[1];
      if ($urandom_range(99) < 5) s[0] = ~s[0];
      send(s);
      if ($urandom_range(15) == 0) idle(1);
    end
    idle(3);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL long_count: got %0d, need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL long_bit[%0d]: got %b, need %b", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (bm_nonzero != 0) begin
      miscompares++;
      $display("FAIL long_best_metric: got %0d nonzero cycles, need 0", bm_nonzero);
    end
    vectors++;
    if (sat_hits != 0) begin
      miscompares++;
      $display("FAIL long_saturation: got %0d saturated metrics, need 0", sat_hits);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bits  = 2'b00;
    repeat (3) @(posedge clk);
    test_reset();
    test_all_zero();
    test_impulse();
    test_error_correction();
    test_gapped();
    test_reset_mid_stream();
    test_long_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
